// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: handshaked byte-addressed data memory with wait states,
// big-endian sub-word access, sign extension and misalignment detection.
module mem_stage_pipe #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        E,
  input  logic        RW,
  input  logic [1:0]  Size,
  input  logic        Signed,
  input  logic        mem_to_reg,
  input  logic [31:0] AD,
  input  logic [31:0] IN,
  input  logic [3:0]  rd_in,
  input  logic        reg_we_in,
  output logic        out_valid,
  output logic [31:0] Out,
  output logic [3:0]  rd_out,
  output logic        reg_we_out,
  output logic        align_fault
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic        rw;
    logic [1:0]  size;
    logic        sgn;
    logic        m2r;
    logic [31:0] ad;
    logic [31:0] din;
    logic [3:0]  rd;
    logic        we;
  } op_t;

  state_t state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  op_t op_q, op_in, cur;
  logic cur_e, is_half, is_word, mis, fault;
  logic accept, long_op, complete, mem_we, load_sel;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;
  logic [31:0] ld;
  logic [7:0] mem [DEPTH];

  assign op_in = '{rw: RW, size: Size, sgn: Signed, m2r: mem_to_reg, ad: AD,
                   din: IN, rd: rd_in, we: reg_we_in};

  // While waiting, the captured op drives the datapath; otherwise the live inputs do.
  always_comb begin
    cur   = op_in;
    cur_e = E;
    if (state == ACCESS) begin
      cur   = op_q;
      cur_e = 1'b1;
    end
  end

  assign is_word  = cur.size[1];
  assign is_half  = (cur.size == 2'b01);
  assign mis      = (is_half & cur.ad[0]) | (is_word & (|cur.ad[1:0]));
  assign fault    = cur_e & mis;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign long_op  = accept & E & ~fault & (WAIT_STATES > 0);
  assign complete = ((state == ACCESS) && (cnt == 3'd0)) | (accept & ~long_op);
  assign mem_we   = complete & cur_e & cur.rw & ~mis & reset;
  assign load_sel = cur.m2r & cur_e & ~cur.rw & ~mis;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (long_op) begin
        state_nxt = ACCESS;
        cnt_nxt   = CNT_INIT;
      end
      ACCESS: if (cnt == 3'd0) state_nxt = IDLE;
              else cnt_nxt = cnt - 3'd1;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      op_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) op_q <= op_in;
    end
  end

  // Big-endian: lowest address carries the most significant byte; indices wrap.
  assign a0 = cur.ad[ADDR_W-1:0];
  assign a1 = a0 + ADDR_W'(1);
  assign a2 = a0 + ADDR_W'(2);
  assign a3 = a0 + ADDR_W'(3);
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    if (is_word)      ld = {b0, b1, b2, b3};
    else if (is_half) ld = {{16{cur.sgn & b0[7]}}, b0, b1};
    else              ld = {{24{cur.sgn & b0[7]}}, b0};
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (is_word) begin
        mem[a0] <= cur.din[31:24];
        mem[a1] <= cur.din[23:16];
        mem[a2] <= cur.din[15:8];
        mem[a3] <= cur.din[7:0];
      end else if (is_half) begin
        mem[a0] <= cur.din[15:8];
        mem[a1] <= cur.din[7:0];
      end else begin
        mem[a0] <= cur.din[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      Out         <= 32'd0;
      rd_out      <= 4'd0;
      reg_we_out  <= 1'b0;
      align_fault <= 1'b0;
    end else begin
      out_valid <= complete;
      if (complete) begin
        Out         <= load_sel ? ld : cur.ad;
        rd_out      <= cur.rd;
        reg_we_out  <= cur.we & ~fault;
        align_fault <= fault;
      end
    end
  end
endmodule
